serial_debug_master: RTL and testbench

Host-side master for the serial debug daisy chain. It converts a parallel 144-bit frame request into the bit-serial rx_data/rx_clk stream that feeds the first serial_debug node. It then captures the 144-bit frame returning from the last node's tx_data/tx_clk and hands it back as a parallel response. It sits between the host/UART bridge logic and the chain, and allows one outstanding transaction at a time, with a timeout.

---
 rtl/serial_debug_master.sv | 191 +++++++++++++++++++
 tb/tb_serial_debug_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_debug_master.sv
// Host-side master for the serial debug daisy chain: serialises a 144-bit request
// onto chain_tx_*, captures the returning frame from chain_rx_*, with timeout.
module serial_debug_master #(
  parameter int TIMEOUT_CYCLES   = 65536,
  parameter int RX_RESYNC_CYCLES = 1024,
  parameter int SYNC_STAGES      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   prescaler,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [143:0] cmd_frame,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [143:0] resp_frame,
  output logic         resp_timeout,
  output logic         stray_frame,
  output logic         chain_tx_data,
  output logic         chain_tx_clk,
  input  logic         chain_rx_data,
  input  logic         chain_rx_clk
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RS_W = $clog2(RX_RESYNC_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, TX, WAIT, RESP} state_t;

  state_t         state;
  logic           armed;
  logic [TO_W-1:0] to_cnt;

  logic           tx_active;
  logic           tx_high;
  logic [7:0]     tx_div;
  logic [7:0]     tx_bits;
  logic [7:0]     presc;
  logic [143:0]   tx_shift;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic           clk_prev;
  logic [142:0]   rx_shift;
  logic [7:0]     rx_cnt;
  logic [RS_W-1:0] rx_hold;

  logic           clk_s;
  logic           data_s;
  logic           rx_rise;
  logic           rx_complete;
  logic [143:0]   rx_word;
  logic           accept;

  assign clk_s       = clk_sync[SYNC_STAGES-1];
  assign data_s      = data_sync[SYNC_STAGES-1];
  assign rx_rise     = clk_s & ~clk_prev;
  assign rx_complete = rx_rise & (rx_cnt == 8'd143);
  assign rx_word     = {rx_shift, data_s};
  assign accept      = cmd_valid & cmd_ready;

  // Receiver: idles with clk high so a reset never fakes a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '0;
      clk_prev  <= 1'b1;
      rx_shift  <= '0;
      rx_cnt    <= '0;
      rx_hold   <= '0;
    end else begin
      clk_sync  <= SYNC_STAGES'({clk_sync, chain_rx_clk});
      data_sync <= SYNC_STAGES'({data_sync, chain_rx_data});
      clk_prev  <= clk_s;
      if (rx_rise) begin
        rx_shift <= rx_word[142:0];
        rx_cnt   <= (rx_cnt == 8'd143) ? 8'd0 : rx_cnt + 8'd1;
        rx_hold  <= '0;
      end else if (clk_s) begin
        // A stalled partial frame is dropped so the next frame aligns from bit 0.
        if (rx_cnt != 8'd0 && rx_hold == RS_W'(RX_RESYNC_CYCLES - 1)) begin
          rx_cnt  <= '0;
          rx_hold <= '0;
        end else if (rx_hold != RS_W'(RX_RESYNC_CYCLES)) begin
          rx_hold <= rx_hold + RS_W'(1);
        end
      end else begin
        rx_hold <= '0;
      end
      if (accept) begin
        rx_cnt  <= '0;
        rx_hold <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_frame    <= '0;
      resp_timeout  <= 1'b0;
      stray_frame   <= 1'b0;
      armed         <= 1'b0;
      to_cnt        <= '0;
      tx_active     <= 1'b0;
      tx_high       <= 1'b0;
      tx_div        <= '0;
      tx_bits       <= '0;
      presc         <= 8'd1;
      tx_shift      <= '0;
      chain_tx_clk  <= 1'b1;
      chain_tx_data <= 1'b0;
    end else begin
      stray_frame <= rx_complete & ~armed;

      // Once the FSM leaves TX the current bit is completed and the lines idle.
      if (tx_active) begin
        if (tx_div == presc - 8'd1) begin
          tx_div <= '0;
          if (!tx_high) begin
            tx_high      <= 1'b1;
            chain_tx_clk <= 1'b1;
          end else if (tx_bits != 8'd0 && state == TX) begin
            tx_high       <= 1'b0;
            chain_tx_clk  <= 1'b0;
            chain_tx_data <= tx_shift[142];
            tx_shift      <= tx_shift << 1;
            tx_bits       <= tx_bits - 8'd1;
          end else begin
            tx_active     <= 1'b0;
            tx_high       <= 1'b0;
            chain_tx_data <= 1'b0;
          end
        end else begin
          tx_div <= tx_div + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready     <= 1'b0;
            tx_shift      <= cmd_frame;
            chain_tx_clk  <= 1'b0;
            chain_tx_data <= cmd_frame[143];
            presc         <= (prescaler == 8'd0) ? 8'd1 : prescaler;
            tx_active     <= 1'b1;
            tx_high       <= 1'b0;
            tx_div        <= '0;
            tx_bits       <= 8'd143;
            to_cnt        <= '0;
            armed         <= 1'b1;
            state         <= TX;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        TX, WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          // A frame completing on the timeout cycle takes priority.
          if (rx_complete && armed) begin
            resp_frame   <= rx_word;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            armed        <= 1'b0;
            state        <= RESP;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
            resp_frame   <= '0;
            resp_timeout <= 1'b1;
            resp_valid   <= 1'b1;
            armed        <= 1'b0;
            state        <= RESP;
          end else if (state == TX && !tx_active) begin
            state <= WAIT;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_debug_master.sv
// Scoreboard bench for serial_debug_master: loopback, timeout, resync/stray and reset cases.
module tb_serial_debug_master;
  localparam int TO = 4096;
  localparam int RS = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   prescaler = 8'd0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [143:0] cmd_frame = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [143:0] resp_frame;
  logic         resp_timeout;
  logic         stray_frame;
  logic         chain_tx_data;
  logic         chain_tx_clk;
  logic         chain_rx_data;
  logic         chain_rx_clk;
  logic         loop_en = 1'b1;
  logic         drv_clk = 1'b1;
  logic         drv_data = 1'b0;

  assign chain_rx_clk  = loop_en ? chain_tx_clk : drv_clk;
  assign chain_rx_data = loop_en ? chain_tx_data : drv_data;

  serial_debug_master #(
    .TIMEOUT_CYCLES(TO),
    .RX_RESYNC_CYCLES(RS),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prescaler(prescaler),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_frame(cmd_frame),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_frame(resp_frame),
    .resp_timeout(resp_timeout), .stray_frame(stray_frame),
    .chain_tx_data(chain_tx_data), .chain_tx_clk(chain_tx_clk),
    .chain_rx_data(chain_rx_data), .chain_rx_clk(chain_rx_clk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic         exp_to_q[$];
  logic [143:0] exp_frame_q[$];
  int  stray_count = 0;
  logic resp_seen = 1'b0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each newly presented response.
  always @(negedge clk) begin
    if (stray_frame) stray_count++;
    if (rst_n && resp_valid && !resp_seen) begin
      resp_seen = 1'b1;
      if (exp_frame_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got frame=%h timeout=%0d expected no response", resp_frame, resp_timeout);
      end else begin
        logic [143:0] ef;
        logic et;
        ef = exp_frame_q.pop_front();
        et = exp_to_q.pop_front();
        $display("resp cyc=%0d frame=%h timeout=%0d", cyc, resp_frame, resp_timeout);
        check("resp_timeout", {143'd0, resp_timeout}, {143'd0, et});
        check("resp_frame", resp_frame, ef);
      end
    end
    if (!resp_valid) resp_seen = 1'b0;
  end

  task automatic expect_resp(input logic to, input logic [143:0] f);
    exp_to_q.push_back(to);
    exp_frame_q.push_back(f);
  endtask

  task automatic send(input logic [143:0] f, input logic [7:0] p, output int acc);
    int i;
    i = 0;
    @(negedge clk);
    while (!cmd_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got cmd_ready=0 expected 1");
    end
    cmd_frame = f;
    prescaler = p;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    prescaler = 8'd5;  // must not disturb the transfer in flight
    acc = cyc;
    $display("cmd cyc=%0d frame=%h presc=%0d", acc, f, p);
  endtask

  task automatic wait_resp(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL resp_wait: got no resp_valid within %0d cycles expected response", budget);
    end
  endtask

  task automatic ack();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("resp_valid_drop", {143'd0, resp_valid}, 144'd0);
    check("cmd_ready_after_ack", {143'd0, cmd_ready}, 144'd1);
  endtask

  // Measures the chain_tx_clk waveform from the negedge after accept.
  task automatic measure_tx(input int p, input int acc, input int n);
    logic prev, c;
    int run, falls, bad_low, bad_high, first_fall, last_rise;
    logic started;
    prev = 1'b1; run = 0; falls = 0; bad_low = 0; bad_high = 0;
    first_fall = -1; last_rise = -1; started = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c = chain_tx_clk;
      if (c != prev) begin
        if (!c) begin
          falls++;
          if (started && run != p) bad_high++;
          if (first_fall < 0) first_fall = cyc;
          started = 1'b1;
        end else begin
          if (run != p) bad_low++;
          last_rise = cyc;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = c;
    end
    check("tx_falls", 144'(falls), 144'd144);
    check("tx_low_phase_errs", 144'(bad_low), 144'd0);
    check("tx_high_phase_errs", 144'(bad_high), 144'd0);
    check("tx_first_fall", 144'(first_fall - acc), 144'd0);
    check("tx_span", 144'(last_rise - acc), 144'(287 * p));
    check("tx_idle_clk", {143'd0, chain_tx_clk}, 144'd1);
    check("tx_idle_data", {143'd0, chain_tx_data}, 144'd0);
  endtask

  task automatic drive_bits(input logic [143:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drv_clk = 1'b0;
      drv_data = v[143 - i];
      @(negedge clk);
      @(negedge clk);
      drv_clk = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #3_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int acc, at, bad, snap;
    logic [143:0] f_a, f_b, f_g, f_e, f_pre, f_stray;
    f_a     = {128'h0, 15'h7FFF, 1'b0};
    f_b     = 144'hA5C30F1E2D3C4B5A69788796A5B4C3D2E1F0;
    f_g     = {128'h12345678_11223344_55667788_99AABBCC, 15'h1234, 1'b1};
    f_e     = 144'hDEADBEEF0123456789ABCDEFFEDCBA987654;
    f_pre   = {9{16'hF0F0}};
    f_stray = {9{16'h3C96}};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_cmd_ready", {143'd0, cmd_ready}, 144'd0);
    check("rst_resp_valid", {143'd0, resp_valid}, 144'd0);
    check("rst_resp_frame", resp_frame, 144'd0);
    check("rst_resp_timeout", {143'd0, resp_timeout}, 144'd0);
    check("rst_stray", {143'd0, stray_frame}, 144'd0);
    check("rst_tx_clk", {143'd0, chain_tx_clk}, 144'd1);
    check("rst_tx_data", {143'd0, chain_tx_data}, 144'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", {143'd0, cmd_ready}, 144'd1);

    // Loopback, prescaler 2, broadcast frame
    loop_en = 1'b1;
    expect_resp(1'b0, f_a);
    send(f_a, 8'd2, acc);
    measure_tx(2, acc, 288 * 2 + 20);
    wait_resp(50, at);
    ack();

    // Loopback, prescaler 0 behaves as 1; then hold the response unaccepted
    expect_resp(1'b0, f_b);
    send(f_b, 8'd0, acc);
    measure_tx(1, acc, 288 + 20);
    wait_resp(50, at);
    bad = 0;
    cmd_frame = f_g;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_frame !== f_b || cmd_ready !== 1'b0) bad++;
    end
    cmd_valid = 1'b0;
    check("hold_stable_errs", 144'(bad), 144'd0);
    ack();

    // Loopback, prescaler 1, identity-style write frame
    expect_resp(1'b0, f_g);
    send(f_g, 8'd1, acc);
    wait_resp(400, at);
    ack();

    // Timeout with the return line idle
    loop_en = 1'b0;
    drv_clk = 1'b1;
    expect_resp(1'b1, 144'd0);
    send(f_a, 8'd1, acc);
    wait_resp(TO + 100, at);
    check("timeout_latency", 144'(at - acc), 144'(TO + 1));
    ack();

    // Partial frame, stall past resync, then a full frame
    expect_resp(1'b0, f_e);
    send(f_b, 8'd1, acc);
    drive_bits(f_pre, 50);
    repeat (RS + 20) @(negedge clk);
    drive_bits(f_e, 144);
    wait_resp(50, at);
    ack();

    // Frame arriving with nothing armed
    snap = stray_count;
    drive_bits(f_stray, 144);
    repeat (10) @(negedge clk);
    check("stray_pulses", 144'(stray_count - snap), 144'd1);
    check("stray_no_resp", {143'd0, resp_valid}, 144'd0);
    check("stray_cmd_ready", {143'd0, cmd_ready}, 144'd1);

    // Reset mid-TX aborts without a response
    loop_en = 1'b1;
    snap = stray_count;
    send(f_b, 8'd2, acc);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx_clk", {143'd0, chain_tx_clk}, 144'd1);
    check("abort_tx_data", {143'd0, chain_tx_data}, 144'd0);
    check("abort_resp_valid", {143'd0, resp_valid}, 144'd0);
    check("abort_cmd_ready", {143'd0, cmd_ready}, 144'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready_release", {143'd0, cmd_ready}, 144'd1);
    repeat (700) @(negedge clk);
    check("abort_stray", 144'(stray_count - snap), 144'd0);
    check("scoreboard_empty", 144'(exp_frame_q.size()), 144'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
